// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus iterative MULT/DIV with HI/LO registers.
// Define EX_STAGE_DIV_EN to build the 32-iteration restoring divider for DIV/DIVU.
module ex_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [31:0] Ins,
  input  logic [31:0] nextPC,
  input  logic [31:0] Rdata1,
  input  logic [31:0] Rdata2,
  input  logic [31:0] Ed32,
  output logic        busy,
  output logic        out_valid,
  output logic [31:0] Result,
  output logic [31:0] Rdata2_o,
  output logic [31:0] Ins_o,
  output logic [31:0] nextPC_o
);
`ifdef EX_STAGE_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] result_q, rdata2_q, ins_q, npc_q, hi_q, lo_q;
  logic        out_valid_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q, opa_q;
  logic [31:0] opb_q;
  logic        sgn_q;

  logic [5:0]  op, funct;
  logic [4:0]  shamt;
  logic        accept, is_mult, is_div, signed_op;
  logic [31:0] abs_a, abs_b, alu_res, fin_hi, fin_lo;
  logic [63:0] prod, mul_acc_nx;

  assign op     = Ins[31:26];
  assign funct  = Ins[5:0];
  assign shamt  = Ins[10:6];
  assign busy   = (state_q != IDLE);
  assign accept = in_valid && !busy;
  assign is_mult = (op == 6'h00) && (funct == 6'h18 || funct == 6'h19);
`ifdef EX_STAGE_DIV_EN
  assign is_div  = (op == 6'h00) && (funct == 6'h1A || funct == 6'h1B);
`else
  assign is_div  = 1'b0;
`endif
  // MULT and DIV have funct[0]==0; the unsigned forms set it
  assign signed_op = !funct[0];
  assign abs_a = (signed_op && Rdata1[31]) ? -Rdata1 : Rdata1;
  assign abs_b = (signed_op && Rdata2[31]) ? -Rdata2 : Rdata2;

  always_comb begin
    alu_res = 32'h0;
    if (op == 6'h00) begin
      case (funct)
        6'h00: alu_res = Rdata2 << shamt;
        6'h02: alu_res = Rdata2 >> shamt;
        6'h03: alu_res = $signed(Rdata2) >>> shamt;
        6'h04: alu_res = Rdata2 << Rdata1[4:0];
        6'h06: alu_res = Rdata2 >> Rdata1[4:0];
        6'h07: alu_res = $signed(Rdata2) >>> Rdata1[4:0];
        6'h10: alu_res = hi_q;
        6'h12: alu_res = lo_q;
        6'h20, 6'h21: alu_res = Rdata1 + Rdata2;
        6'h22, 6'h23: alu_res = Rdata1 - Rdata2;
        6'h24: alu_res = Rdata1 & Rdata2;
        6'h25: alu_res = Rdata1 | Rdata2;
        6'h26: alu_res = Rdata1 ^ Rdata2;
        6'h27: alu_res = ~(Rdata1 | Rdata2);
        6'h2A: alu_res = {31'h0, $signed(Rdata1) < $signed(Rdata2)};
        6'h2B: alu_res = {31'h0, Rdata1 < Rdata2};
        default: alu_res = 32'h0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09, 6'h23, 6'h2B: alu_res = Rdata1 + Ed32;
        6'h0A: alu_res = {31'h0, $signed(Rdata1) < $signed(Ed32)};
        6'h0B: alu_res = {31'h0, Rdata1 < Ed32};
        6'h0C: alu_res = Rdata1 & {16'h0, Ins[15:0]};
        6'h0D: alu_res = Rdata1 | {16'h0, Ins[15:0]};
        6'h0E: alu_res = Rdata1 ^ {16'h0, Ins[15:0]};
        6'h0F: alu_res = {Ins[15:0], 16'h0};
        default: alu_res = 32'h0;
      endcase
    end
  end

  assign mul_acc_nx = opb_q[0] ? acc_q + opa_q : acc_q;

`ifdef EX_STAGE_DIV_EN
  // Divide: acc_q = {remainder, dividend/quotient}; opa_q[31:0] keeps the raw dividend.
  logic        is_div_q, rneg_q, dz_q;
  logic [33:0] trial;
  logic [63:0] div_acc_nx;
  assign trial      = {1'b0, acc_q[63:31]} - {2'b0, opb_q};
  assign div_acc_nx = trial[33] ? {acc_q[62:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1};
`endif

  always_comb begin
    prod   = sgn_q ? -acc_q : acc_q;
    fin_hi = prod[63:32];
    fin_lo = prod[31:0];
`ifdef EX_STAGE_DIV_EN
    if (is_div_q) begin
      if (dz_q) begin
        fin_hi = opa_q[31:0];
        fin_lo = 32'hFFFF_FFFF;
      end else begin
        fin_hi = rneg_q ? -acc_q[63:32] : acc_q[63:32];
        fin_lo = sgn_q  ? -acc_q[31:0]  : acc_q[31:0];
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_mult)     state_d = MUL;
            else if (accept && is_div) state_d = state_t'(2'd2);
      MUL:  if (cnt_q == 5'd31) state_d = DONE;
`ifdef EX_STAGE_DIV_EN
      DIV:  if (cnt_q == 5'd31) state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid_q <= 1'b0;
      result_q <= '0; rdata2_q <= '0; ins_q <= '0; npc_q <= '0;
      hi_q <= '0; lo_q <= '0; cnt_q <= '0;
      acc_q <= '0; opa_q <= '0; opb_q <= '0; sgn_q <= 1'b0;
`ifdef EX_STAGE_DIV_EN
      is_div_q <= 1'b0; rneg_q <= 1'b0; dz_q <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        rdata2_q <= Rdata2;
        ins_q    <= Ins;
        npc_q    <= nextPC;
        cnt_q    <= '0;
        sgn_q    <= signed_op && (Rdata1[31] ^ Rdata2[31]);
`ifdef EX_STAGE_DIV_EN
        is_div_q <= is_div;
        rneg_q   <= signed_op && Rdata1[31];
        dz_q     <= (Rdata2 == 32'h0);
`endif
        if (is_mult) begin
          acc_q <= '0;
          opa_q <= {32'h0, abs_a};
          opb_q <= abs_b;
        end else if (is_div) begin
          acc_q <= {32'h0, abs_a};
          opa_q <= {32'h0, Rdata1};
          opb_q <= abs_b;
        end else begin
          result_q    <= alu_res;
          out_valid_q <= 1'b1;
        end
      end
      if (state_q == MUL) begin
        acc_q <= mul_acc_nx;
        opa_q <= opa_q << 1;
        opb_q <= opb_q >> 1;
        cnt_q <= cnt_q + 5'd1;
      end
`ifdef EX_STAGE_DIV_EN
      if (state_q == DIV) begin
        acc_q <= div_acc_nx;
        cnt_q <= cnt_q + 5'd1;
      end
`endif
      if (state_q == DONE) begin
        hi_q        <= fin_hi;
        lo_q        <= fin_lo;
        result_q    <= fin_lo;
        out_valid_q <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Rdata2_o  = rdata2_q;
  assign Ins_o     = ins_q;
  assign nextPC_o  = npc_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, address generation, MULT/DIV latency, stall and reset abort.
module tb_ex_stage;
  logic        CLK, RST, in_valid;
  logic [31:0] Ins, nextPC, Rdata1, Rdata2, Ed32;
  logic        busy, out_valid;
  logic [31:0] Result, Rdata2_o, Ins_o, nextPC_o;
  int tests, fails, n, pulses;

  ex_stage dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .Ins(Ins), .nextPC(nextPC),
    .Rdata1(Rdata1), .Rdata2(Rdata2), .Ed32(Ed32), .busy(busy),
    .out_valid(out_valid), .Result(Result), .Rdata2_o(Rdata2_o),
    .Ins_o(Ins_o), .nextPC_o(nextPC_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] ed, input logic [31:0] pc);
    Ins = ins; Rdata1 = r1; Rdata2 = r2; Ed32 = ed; nextPC = pc; in_valid = 1'b1;
  endtask

  // Present one instruction for a single posedge, then return at the following negedge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] ed, input logic [31:0] pc);
    @(negedge CLK);
    drive(ins, r1, r2, ed, pc);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // Count busy cycles (bounded) and any out_valid seen while busy.
  task automatic wait_idle(output int cyc, output int early);
    cyc = 0; early = 0;
    while (busy && cyc < 100) begin
      if (out_valid) early++;
      cyc++;
      @(negedge CLK);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    RST = 1'b0; in_valid = 1'b0;
    Ins = '0; nextPC = '0; Rdata1 = '0; Rdata2 = '0; Ed32 = '0;
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", Result, 32'h0);
    chk("rst_ins_o", Ins_o, 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    issue(32'h0000_0021, 32'd5, 32'd7, 32'h0, 32'h0000_1004);       // ADDU
    chk("addu_result", Result, 32'd12);
    chk("addu_valid", {31'h0, out_valid}, 32'h1);
    chk("addu_ins_o", Ins_o, 32'h0000_0021);
    chk("addu_npc_o", nextPC_o, 32'h0000_1004);
    @(negedge CLK);
    chk("addu_valid_drop", {31'h0, out_valid}, 32'h0);

    issue(32'h8C00_FFFC, 32'h10, 32'h55, 32'hFFFF_FFFC, 32'h8);      // LW
    chk("lw_addr", Result, 32'h0000_000C);
    issue(32'hAC00_FFFC, 32'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'hC); // SW
    chk("sw_addr", Result, 32'h0000_000C);
    chk("sw_rdata2_o", Rdata2_o, 32'hDEAD_BEEF);

    issue(32'h0000_0023, 32'd5, 32'd7, 32'h0, 32'h0);               // SUBU
    chk("subu", Result, 32'hFFFF_FFFE);
    issue(32'h0000_0027, 32'h0, 32'hFFFF_0000, 32'h0, 32'h0);       // NOR
    chk("nor", Result, 32'h0000_FFFF);
    issue(32'h0000_002A, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);       // SLT
    chk("slt", Result, 32'h1);
    issue(32'h0000_002B, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);       // SLTU
    chk("sltu", Result, 32'h0);
    issue(32'h0000_0103, 32'h0, 32'h8000_0000, 32'h0, 32'h0);       // SRA 4
    chk("sra", Result, 32'hF800_0000);
    issue(32'h0000_0004, 32'd8, 32'h1, 32'h0, 32'h0);               // SLLV by 8
    chk("sllv", Result, 32'h0000_0100);
    issue(32'h3C00_1234, 32'hFFFF_FFFF, 32'h0, 32'h0000_1234, 32'h0); // LUI
    chk("lui", Result, 32'h1234_0000);
    issue(32'h3400_F0F0, 32'h0F00_0000, 32'h0, 32'hFFFF_F0F0, 32'h0); // ORI zero-ext
    chk("ori", Result, 32'h0F00_F0F0);
    issue(32'h0C00_0010, 32'h3, 32'h4, 32'h0, 32'h0000_2008);       // JAL
    chk("jal_result", Result, 32'h0);
    chk("jal_npc_o", nextPC_o, 32'h0000_2008);
    issue(32'h0000_0021, 32'd1, 32'd1, 32'h0, 32'h0);
    issue(32'hFC00_0000, 32'd1, 32'd1, 32'h0, 32'h0);               // unknown op
    chk("unk_result", Result, 32'h0);
    chk("unk_valid", {31'h0, out_valid}, 32'h1);

    issue(32'h0000_0018, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0);       // MULT
    chk("mult_busy", {31'h0, busy}, 32'h1);
    wait_idle(n, pulses);
    chk("mult_latency", n, 32'd33);
    chk("mult_early_valid", pulses, 32'd0);
    chk("mult_valid", {31'h0, out_valid}, 32'h1);
    chk("mult_lo", Result, 32'hFFFF_FFFA);
    drive(32'h0000_0010, 32'h0, 32'h0, 32'h0, 32'h0);               // MFHI straight away
    @(negedge CLK); in_valid = 1'b0;
    chk("mfhi", Result, 32'hFFFF_FFFF);
    issue(32'h0000_0012, 32'h0, 32'h0, 32'h0, 32'h0);               // MFLO
    chk("mflo", Result, 32'hFFFF_FFFA);

`ifdef EX_STAGE_DIV_EN
    issue(32'h0000_001A, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0);       // DIV -7/2
    wait_idle(n, pulses);
    chk("div_latency", n, 32'd33);
    chk("div_lo", Result, 32'hFFFF_FFFD);
    issue(32'h0000_0010, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("div_hi", Result, 32'hFFFF_FFFF);
    issue(32'h0000_001B, 32'd9, 32'd0, 32'h0, 32'h0);               // DIVU 9/0
    wait_idle(n, pulses);
    chk("divz_latency", n, 32'd33);
    chk("divz_lo", Result, 32'hFFFF_FFFF);
    issue(32'h0000_0010, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("divz_hi", Result, 32'd9);
    issue(32'h0000_001A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0); // overflow case
    wait_idle(n, pulses);
    chk("divovf_lo", Result, 32'h8000_0000);
    issue(32'h0000_0010, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("divovf_hi", Result, 32'h0);
`else
    issue(32'h0000_001A, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0);       // DIV disabled
    chk("div_off_busy", {31'h0, busy}, 32'h0);
    chk("div_off_valid", {31'h0, out_valid}, 32'h1);
    chk("div_off_result", Result, 32'h0);
    issue(32'h0000_0010, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("div_off_hi", Result, 32'hFFFF_FFFF);
`endif

    // MULTU in flight while ADDU waits with in_valid held high
    @(negedge CLK);
    drive(32'h0000_0019, 32'd3, 32'd4, 32'h0, 32'h0);
    @(negedge CLK);
    drive(32'h0000_0021, 32'd100, 32'd1, 32'h0, 32'h0);
    wait_idle(n, pulses);
    chk("stall_latency", n, 32'd33);
    if (out_valid) pulses++;
    chk("stall_multu", Result, 32'd12);
    @(negedge CLK);
    in_valid = 1'b0;
    if (out_valid) pulses++;
    chk("stall_addu", Result, 32'd101);
    repeat (5) begin
      @(negedge CLK);
      if (out_valid) pulses++;
    end
    chk("stall_pulses", pulses, 32'd2);

    // Reset at iteration 10 of MULT
    issue(32'h0000_0018, 32'd5, 32'd6, 32'h0, 32'h0);
    repeat (9) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_result", Result, 32'h0);
    chk("abort_ins_o", Ins_o, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge CLK);
      if (out_valid) pulses++;
    end
    chk("abort_no_valid", pulses, 32'd0);
    issue(32'h0000_0012, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("abort_mflo", Result, 32'h0);
    issue(32'h0000_0010, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("abort_mfhi", Result, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
